// File: rtl/branch_cmp_pkg.sv
// ============================================================================
// branch_cmp_pkg : shared state encodings, defaults and flag resolution for
//                  the sequential branch comparator.
// Revision 1.0
// ============================================================================
`default_nettype none

package branch_cmp_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Field order matches the mux6x1_1b input order.
  typedef struct packed {
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic bltu;
    logic bgeu;
  } flags_t;

  function automatic flags_t resolve_flags(
    input logic differ,
    input logic ult,
    input logic sdiff,
    input logic a_msb
  );
    flags_t f;
    f = '0;
    if (!differ) begin
      f.beq  = 1'b1;
      f.bge  = 1'b1;
      f.bgeu = 1'b1;
    end else begin
      f.bne  = 1'b1;
      f.bltu = ult;
      f.bgeu = ~ult;
      // Opposite signs: the negative operand is the smaller one.
      f.blt  = sdiff ? a_msb : ult;
      f.bge  = ~f.blt;
    end
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_cmp.sv
// ============================================================================
// chunk_cmp : combinational equality / unsigned less-than of one chunk.
// Revision 1.0
// ============================================================================
`default_nettype none

module chunk_cmp #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             ult
);

  assign eq  = (a == b);
  assign ult = (a < b);

endmodule

`default_nettype wire

// File: rtl/branch_cmp_seq.sv
// ============================================================================
// branch_cmp_seq : multi-cycle MSB-chunk-first operand comparator producing
//                  the six registered branch condition flags.
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_cmp_seq
  import branch_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             BEQ,
  output logic             BNE,
  output logic             BLT,
  output logic             BGE,
  output logic             BLTU,
  output logic             BGEU
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  state_e          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx_q;
  logic             sdiff_q;
  logic             busy_q;
  logic             done_q;
  flags_t           flags_q;
  flags_t           flags_d;

  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  logic             chunk_eq;
  logic             chunk_ult;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign a_chunks[gi] = a_q[gi*CHUNK +: CHUNK];
    assign b_chunks[gi] = b_q[gi*CHUNK +: CHUNK];
  end

  chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_chunk_cmp (
    .a   (a_chunks[idx_q]),
    .b   (b_chunks[idx_q]),
    .eq  (chunk_eq),
    .ult (chunk_ult)
  );

  assign flags_d = resolve_flags(~chunk_eq, chunk_ult, sdiff_q, a_q[WIDTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      sdiff_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            idx_q   <= IDX_TOP;
            sdiff_q <= A[WIDTH-1] ^ B[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          // Decided either by the first differing chunk or by exhausting all chunks.
          if (!chunk_eq || (idx_q == '0)) begin
            flags_q <= flags_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign BEQ  = flags_q.beq;
  assign BNE  = flags_q.bne;
  assign BLT  = flags_q.blt;
  assign BGE  = flags_q.bge;
  assign BLTU = flags_q.bltu;
  assign BGEU = flags_q.bgeu;

endmodule

`default_nettype wire

// File: tb/tb_branch_cmp_seq.sv
// ============================================================================
// tb_branch_cmp_seq : directed vector bench for branch_cmp_seq.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_branch_cmp_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic        BEQ, BNE, BLT, BGE, BLTU, BGEU;
  logic [5:0]  w_flags;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lat;
    logic [5:0]  flags;   // {BEQ,BNE,BLT,BGE,BLTU,BGEU}
  } vec_t;

  vec_t vecs [10];

  branch_cmp_seq #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .BEQ   (BEQ),
    .BNE   (BNE),
    .BLT   (BLT),
    .BGE   (BGE),
    .BLTU  (BLTU),
    .BGEU  (BGEU)
  );

  assign w_flags = {BEQ, BNE, BLT, BGE, BLTU, BGEU};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench #1 after the accepting edge with start already low.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Cycle 1 is the one just after the accepting edge; done is expected in cycle exp_lat.
  task automatic wait_done(input int exp_lat, input logic [5:0] exp_flags,
                           input bit inject, input bit hold_chk, input logic [5:0] old_flags);
    int cnt;
    bit seen;
    cnt  = 1;
    seen = 1'b0;
    if (inject) begin
      start = 1'b1;
      A     = 32'h8000_0000;
      B     = 32'h0000_0001;
    end
    for (int k = 2; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (inject && k == 2) start = 1'b0;
      cnt = k;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (hold_chk) check("flags_hold_in_compare", {26'd0, w_flags}, {26'd0, old_flags});
      check("busy_in_compare", {31'd0, busy}, 32'd1);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done in cycle %0d", exp_lat);
    end else begin
      check("latency", cnt, exp_lat);
      check("flags", {26'd0, w_flags}, {26'd0, exp_flags});
      check("busy_with_done", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check("done_pulse_width", {31'd0, done}, 32'd0);
      check("busy_falls", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0005, 32'd5, 6'b100101};
    vecs[1] = '{32'h1000_0000, 32'h2000_0000, 32'd2, 6'b011010};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'd2, 6'b011001};
    vecs[3] = '{32'h0000_0100, 32'h0000_00FF, 32'd4, 6'b010101};
    vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd2, 6'b011001};
    vecs[5] = '{32'h1234_5678, 32'h1234_5679, 32'd5, 6'b011010};
    vecs[6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd5, 6'b011010};
    vecs[7] = '{32'h7F00_0000, 32'h8000_0000, 32'd2, 6'b010110};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 32'd5, 6'b100101};
    vecs[9] = '{32'h0012_0000, 32'h0011_0000, 32'd3, 6'b010101};

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_flags", {26'd0, w_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_done(int'(vecs[i].lat), vecs[i].flags, 1'b0, 1'b0, 6'd0);
    end

    // Reset aborts a comparison in flight; flags from the last vector are non-zero here.
    start_op(32'h0000_0007, 32'h0000_0007);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_flags", {26'd0, w_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("no_done_after_abort", {31'd0, done}, 32'd0);
    end
    start_op(32'h0000_0001, 32'h0000_0002);
    wait_done(5, 6'b011010, 1'b0, 1'b0, 6'd0);

    // Start during COMPARE is dropped; result then holds through idle and the next COMPARE.
    start_op(32'h0000_0010, 32'h0000_0010);
    wait_done(5, 6'b100101, 1'b1, 1'b0, 6'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("flags_hold_idle", {26'd0, w_flags}, {26'd0, 6'b100101});
      check("idle_no_done", {31'd0, done}, 32'd0);
    end
    start_op(32'h0000_0001, 32'h0000_0002);
    check("flags_hold_at_accept", {26'd0, w_flags}, {26'd0, 6'b100101});
    wait_done(5, 6'b011010, 1'b0, 1'b1, 6'b100101);

    // Back-to-back: restart in the first idle cycle after DONE.
    start_op(32'h2000_0000, 32'h1000_0000);
    wait_done(2, 6'b010101, 1'b0, 1'b0, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/branch_cmp_seq.md
# branch_cmp_seq

Multi-cycle branch comparator that sits directly upstream of the branch-flag mux (`mux6x1_1b`). It compares two register operands MSB-chunk-first, stopping early at the first differing chunk, and produces the six branch condition flags. `mux6x1_1b` then reduces those flags to one `selectedFlag` using `funct3`. A start/busy/done handshake replaces the single-cycle comparator, which keeps the critical path short in the datapath.

## Interface
Parameters:
- `WIDTH`, 32: operand width in bits; must be an integer multiple of `CHUNK`.
- `CHUNK`, 8: bits compared per cycle; `NCHUNK = WIDTH/CHUNK`.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a comparison; sampled only in IDLE.
- `A`  in  WIDTH  operand rs1; captured on the accepted start.
- `B`  in  WIDTH  operand rs2; captured on the accepted start.
- `busy`  out  1  high while in COMPARE or DONE.
- `done`  out  1  one-cycle pulse when the flags are valid and updated.
- `BEQ`, `BNE`, `BLT`, `BGE`, `BLTU`, `BGEU`  out  1 each  condition flags, in the same order and with the same meaning as the `mux6x1_1b` inputs.

## Operation
- State machine, three states:
  - IDLE -> COMPARE on `start`=1. In the same edge: latch `A`/`B`, set `idx` to NCHUNK-1 (top chunk), and compute `sdiff = A[WIDTH-1] ^ B[WIDTH-1]`.
  - COMPARE: each cycle, compare chunk `idx` of the latched operands.
    - Chunks differ: the result is decided; go to DONE.
    - Chunks equal and `idx`==0: operands are equal; go to DONE.
    - Otherwise: `idx` <= `idx`-1 and stay in COMPARE.
  - DONE -> IDLE unconditionally after one cycle.
- Result rules, where `ult` is the unsigned less-than of the first differing chunk:
  - Equal: BEQ=1, BGE=1, BGEU=1; all other flags 0.
  - Differ: BNE=1, BLTU=`ult`, BGEU=!`ult`, BLT = `sdiff` ? latched A MSB : `ult`, BGE = !BLT, BEQ=0.
- Flags are registered. They update only on the edge entering DONE and hold their value through IDLE and the next COMPARE until the next result.
- Exactly one of BEQ/BNE is high after the first result; BLT ^ BGE = 1 and BLTU ^ BGEU = 1.
- `start` in COMPARE or DONE is ignored and dropped; upstream retries only when `busy`=0.
- Comparison is purely bitwise; there are no X/overflow cases because no subtraction is used.

## Timing
- Reset (asynchronous): state=IDLE; `busy`=0, `done`=0, all six flags=0; latched operands and `idx` cleared.
- Reset asserted mid-COMPARE or in DONE aborts the comparison. No `done` is produced and the flags read 0 immediately.
- Let `start` be accepted at edge T0, and let the result be decided at chunk position j (0 = top chunk).
  - COMPARE occupies cycles T0+1 … T0+1+j.
  - Flags and `done` become valid after edge T0+2+j.
  - Minimum latency is 2 cycles (j=0); maximum is NCHUNK+1 cycles (5 for defaults, including the equal case).
- `busy` is high from after T0 through the DONE cycle. `busy` falls with `done`'s falling edge.
- Back-to-back operation: a new `start` is accepted in the first IDLE cycle after DONE, giving a minimum 3-cycle issue interval.

## Structure
- Shared package/header `branch_cmp_pkg` holds the state encodings (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2) and defaults for WIDTH/CHUNK.
- One combinational sub-module, `chunk_cmp` (parameter `CHUNK`; inputs a, b; outputs eq, ult), is instantiated once and fed by the `idx` select.
- The top level contains the FSM, operand registers, `idx` down-counter and flag registers.

## Test plan
- A=B=0x00000005, start -> `done` at T0+5; BEQ=BGE=BGEU=1, BNE=BLT=BLTU=0; `busy` high 4 COMPARE + 1 DONE cycles.
- A=0x10000000, B=0x20000000 -> `done` at T0+2; BNE=BLT=BLTU=1, BEQ=BGE=BGEU=0.
- A=0xFFFFFFFF, B=0x00000001 (signs differ) -> `done` at T0+2; BNE=1, BLT=1, BGE=0, BLTU=0, BGEU=1.
- A=0x00000100, B=0x000000FF -> decided at j=2, `done` at T0+4; BNE=BGE=BGEU=1, BLT=BLTU=0.
- Start with A=B, pulse `reset` at T0+2 -> outputs all 0 that cycle, no `done`. After release, A=1, B=2 -> BNE=BLT=BLTU=1 at T0'+5.
- `start` pulsed during COMPARE with different operands -> ignored, the original result is delivered; flags then hold across 10 idle cycles and through the next COMPARE until its `done`.
